cache_control: RTL

- Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache in mp2.
- Sequences the per-way tag/valid/dirty/data arrays and the shared LRU array. These are registered-read arrays: read data appears the cycle after `read` is asserted, and a same-cycle load returns the old data.
- Handshakes with the CPU (mem_*) and physical memory (pmem_*).
- Selects the victim way, and drives writeback and line fill.

---
 rtl/cache_control.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_control.sv
// cache_control: control FSM for the 2-way set-associative, write-back, write-allocate L1 cache.
// Ports: CPU handshake (mem_*), physical memory handshake (pmem_*), array status in (hit/valid/dirty/lru),
//        array control out (array_read, load_*, *_in, data_in_sel, way_sel, pmem_addr_sel).
// Optional: define CACHE_PERF_CNT_EN to add hit_count/miss_count/wb_count (CNT_WIDTH bits, wrapping).
// Latency: hit responds one cycle after IDLE sees the request; misses add writeback/fill + REREAD.
// Backpressure: CPU request is held until mem_resp; pmem request is held constant until pmem_resp.
module cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    input  logic [1:0] hit,
    input  logic [1:0] valid,
    input  logic [1:0] dirty,
    input  logic       lru,
    output logic       array_read,
    output logic [1:0] load_tag,
    output logic [1:0] load_valid,
    output logic [1:0] load_dirty,
    output logic       dirty_in,
    output logic [1:0] load_data,
    output logic       data_in_sel,
    output logic       load_lru,
    output logic       lru_in,
    output logic       way_sel,
    output logic       pmem_addr_sel
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL,
        REREAD
    } state_t;

    state_t state, state_next;
    logic   victim, victim_next;

    logic req;
    logic hit_way;
    logic victim_pick;
    logic hit_evt, miss_evt, wb_evt;

    function automatic logic [1:0] way_onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    assign req         = mem_read | mem_write;
    // hit=2'b11 should never happen; way 0 takes priority if it does.
    assign hit_way     = ~hit[0];
    // Fill an empty way before evicting anything.
    assign victim_pick = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state  <= state_next;
            victim <= victim_next;
        end
    end

    // Outputs are decoded from the state register; COMPARE also looks at the
    // array outputs of the same cycle, so they cannot be registered.
    // Because state resets asynchronously, pmem_* drop as soon as rst rises.
    always_comb begin
        state_next    = state;
        victim_next   = victim;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        array_read    = 1'b0;
        load_tag      = 2'b00;
        load_valid    = 2'b00;
        load_dirty    = 2'b00;
        dirty_in      = 1'b0;
        load_data     = 2'b00;
        data_in_sel   = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        way_sel       = 1'b0;
        pmem_addr_sel = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;
        wb_evt        = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    array_read = 1'b1;
                    state_next = COMPARE;
                end
            end

            COMPARE: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (|hit) begin
                    hit_evt    = 1'b1;
                    mem_resp   = 1'b1;
                    way_sel    = hit_way;
                    load_lru   = 1'b1;
                    lru_in     = ~hit_way;
                    // Writes merge into the hit line; write takes priority over read.
                    if (mem_write) begin
                        load_data   = way_onehot(hit_way);
                        data_in_sel = 1'b0;
                        load_dirty  = way_onehot(hit_way);
                        dirty_in    = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    miss_evt    = 1'b1;
                    victim_next = victim_pick;
                    if (valid[victim_pick] && dirty[victim_pick])
                        state_next = WRITEBACK;
                    else
                        state_next = FILL;
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim;
                if (pmem_resp) begin
                    wb_evt     = 1'b1;
                    load_dirty = way_onehot(victim);
                    dirty_in   = 1'b0;
                    state_next = FILL;
                end
            end

            FILL: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                way_sel       = victim;
                if (pmem_resp) begin
                    load_data   = way_onehot(victim);
                    load_tag    = way_onehot(victim);
                    load_valid  = way_onehot(victim);
                    load_dirty  = way_onehot(victim);
                    dirty_in    = 1'b0;
                    data_in_sel = 1'b1;
                    state_next  = REREAD;
                end
            end

            REREAD: begin
                // Re-read the freshly filled line so COMPARE hits and merges writes.
                array_read = 1'b1;
                state_next = COMPARE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    // Marks a COMPARE that follows REREAD; its hit completes a miss and is not a new hit.
    logic from_reread;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            from_reread <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
            wb_count    <= '0;
        end else begin
            from_reread <= (state == REREAD);
            if (hit_evt && !from_reread)
                hit_count <= hit_count + 1'b1;
            if (miss_evt)
                miss_count <= miss_count + 1'b1;
            if (wb_evt)
                wb_count <= wb_count + 1'b1;
        end
    end
`else
    // Event strobes feed only the optional counters.
    logic unused_evt;
    assign unused_evt = hit_evt ^ miss_evt ^ wb_evt;
`endif

endmodule
